// File: rtl/io_stage_pkg.sv
// Shared types for the memory-access stage: load kinds, FSM states and the
// stage's outgoing buses, plus the EX->IO bus consumed by io_stage.
package io_stage_params;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned STRB_W    = 4;

    typedef enum logic [2:0] {
        LW  = 3'd0,
        LB  = 3'd1,
        LBU = 3'd2,
        LH  = 3'd3,
        LHU = 3'd4,
        LWL = 3'd5,
        LWR = 3'd6
    } LoadType;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        WAIT_DATA = 2'd1,
        READY     = 2'd2
    } IOState;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      program_count;
        logic                 register_file_write_enabled;
        logic [STRB_W-1:0]    register_file_write_strobe;
        logic [RF_ADDR_W-1:0] register_file_address;
        logic [XLEN-1:0]      final_result;
    } IOToWBData;

    typedef struct packed {
        logic                 valid;
        logic                 data_pending;
        logic [RF_ADDR_W-1:0] write_register;
        logic [STRB_W-1:0]    write_strobe;
        logic [XLEN-1:0]      write_data;
    } IOToIDBackPassData;

    function automatic logic [XLEN-1:0] sext8(input logic [7:0] b);
        return {{(XLEN-8){b[7]}}, b};
    endfunction

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] h);
        return {{(XLEN-16){h[15]}}, h};
    endfunction

endpackage

package ex_stage_params;

    typedef struct packed {
        logic                                    valid;
        logic [io_stage_params::XLEN-1:0]        program_count;
        logic [io_stage_params::XLEN-1:0]        alu_result;
        io_stage_params::LoadType                load_type;
        logic                                    is_load;
        logic                                    register_file_write_enabled;
        logic [io_stage_params::RF_ADDR_W-1:0]   register_file_address;
    } EXToIOData;

endpackage

// File: rtl/io_stage_load_aligner.sv
// Combinational load-data aligner/extender with register-file byte strobe.
// LWL/LWR merging is decoded only when IO_UNALIGNED_LOAD_EN is defined.
module load_aligner
    import io_stage_params::*;
(
    input  LoadType     load_type,
    input  logic [1:0]  address,
    input  logic [31:0] rdata,
    output logic [31:0] result,
    output logic [3:0]  strobe
);

    logic [4:0]  lane_shift_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
`ifdef IO_UNALIGNED_LOAD_EN
    logic [1:0]  lwl_lanes_s;
`endif

    // Select the addressed lane and extend/merge according to load kind
    always_comb begin
        lane_shift_s = {address, 3'b000};
        byte_s       = 8'(rdata >> lane_shift_s);
        half_s       = address[1] ? rdata[31:16] : rdata[15:0];
        result       = rdata;
        strobe       = 4'b1111;
`ifdef IO_UNALIGNED_LOAD_EN
        lwl_lanes_s  = 2'd3 - address;
`endif
        case (load_type)
            LW:  result = rdata;
            LB:  result = sext8(byte_s);
            LBU: result = {24'd0, byte_s};
            LH:  result = sext16(half_s);
            LHU: result = {16'd0, half_s};
`ifdef IO_UNALIGNED_LOAD_EN
            // Low memory bytes fill the top of the register; WB merges by strobe
            LWL: begin
                result = rdata << {lwl_lanes_s, 3'b000};
                strobe = 4'b1111 << lwl_lanes_s;
            end
            LWR: begin
                result = rdata >> lane_shift_s;
                strobe = 4'b1111 >> address;
            end
`else
            LWL, LWR: begin
                result = rdata;
                strobe = 4'b1111;
            end
`endif
            default: begin
                result = rdata;
                strobe = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/io_stage.sv
// Memory-access pipeline stage between EX and WB: waits for load data,
// aligns it, and publishes forwarding info to ID. Optional: IO_UNALIGNED_LOAD_EN.
module io_stage
    import io_stage_params::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  ex_stage_params::EXToIOData ex_to_io_bus,
    output logic                       io_allow_in,
    input  logic                       wb_allow_in,
    output IOToWBData                  io_to_wb_bus,
    output IOToIDBackPassData          io_to_id_back_pass_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata
);

    IOState               state_q, state_d;
    logic [XLEN-1:0]      pc_q;
    logic                 rf_we_q;
    logic [RF_ADDR_W-1:0] rf_addr_q;
    LoadType              load_type_q;
    logic [1:0]           addr_lo_q;
    logic [XLEN-1:0]      result_q;
    logic [STRB_W-1:0]    strobe_q;

    logic                 accept_s;
    logic                 io_valid_s;
    logic [31:0]          aligned_s;
    logic [3:0]           aligned_strobe_s;

    load_aligner u_load_aligner (
        .load_type (load_type_q),
        .address   (addr_lo_q),
        .rdata     (data_sram_rdata),
        .result    (aligned_s),
        .strobe    (aligned_strobe_s)
    );

    // Next-state and handshake; a new accept overrides the drain transition
    always_comb begin
        state_d     = state_q;
        io_allow_in = 1'b0;
        case (state_q)
            EMPTY: begin
                io_allow_in = 1'b1;
                state_d     = EMPTY;
            end
            WAIT_DATA: begin
                io_allow_in = 1'b0;
                if (data_sram_data_ok) begin
                    state_d = READY;
                end else begin
                    state_d = WAIT_DATA;
                end
            end
            READY: begin
                io_allow_in = wb_allow_in;
                if (wb_allow_in) begin
                    state_d = EMPTY;
                end else begin
                    state_d = READY;
                end
            end
            default: begin
                io_allow_in = 1'b0;
                state_d     = EMPTY;
            end
        endcase
        accept_s = io_allow_in & ex_to_io_bus.valid;
        if (accept_s) begin
            state_d = ex_to_io_bus.is_load ? WAIT_DATA : READY;
        end else begin
            state_d = state_d;
        end
    end

    // State register; only control state is reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: capture on accept, overwrite result when load data returns
    always_ff @(posedge clock) begin
        if (accept_s) begin
            pc_q        <= ex_to_io_bus.program_count;
            rf_we_q     <= ex_to_io_bus.register_file_write_enabled;
            rf_addr_q   <= ex_to_io_bus.register_file_address;
            load_type_q <= ex_to_io_bus.load_type;
            addr_lo_q   <= ex_to_io_bus.alu_result[1:0];
            result_q    <= ex_to_io_bus.alu_result;
            strobe_q    <= 4'b1111;
        end else if ((state_q == WAIT_DATA) && data_sram_data_ok) begin
            result_q    <= aligned_s;
            strobe_q    <= aligned_strobe_s;
        end else begin
            result_q    <= result_q;
            strobe_q    <= strobe_q;
        end
    end

    // Output buses decoded from registered state and data
    always_comb begin
        io_valid_s = (state_q != EMPTY);

        io_to_wb_bus.valid                       = (state_q == READY);
        io_to_wb_bus.program_count               = pc_q;
        io_to_wb_bus.register_file_write_enabled = rf_we_q;
        io_to_wb_bus.register_file_write_strobe  = strobe_q;
        io_to_wb_bus.register_file_address       = rf_addr_q;
        io_to_wb_bus.final_result                = result_q;

        io_to_id_back_pass_bus.valid          = io_valid_s & rf_we_q;
        io_to_id_back_pass_bus.data_pending   = (state_q == WAIT_DATA);
        io_to_id_back_pass_bus.write_register = rf_addr_q;
        io_to_id_back_pass_bus.write_strobe   = strobe_q;
        io_to_id_back_pass_bus.write_data     = result_q;
    end

endmodule
